// File: rtl/minrv32_dbus_if.sv
// Core-side request/response and bus-side request/response signals of the data-bus adapter.
// The adapter uses the master view; the environment (core plus memory) uses the slave view.
interface minrv32_dbus_if;
  logic        core_valid;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_wmask;
  logic [3:0]  core_rmask;
  logic        core_ready;
  logic [31:0] core_rdata;
  logic        core_err;

  logic        bus_valid;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    input  core_valid, core_addr, core_wdata, core_wmask, core_rmask,
    output core_ready, core_rdata, core_err,
    output bus_valid, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rdata, bus_err
  );

  modport slave (
    output core_valid, core_addr, core_wdata, core_wmask, core_rmask,
    input  core_ready, core_rdata, core_err,
    input  bus_valid, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rdata, bus_err
  );
endinterface

// File: rtl/minrv32_dbus.sv
// Data-bus adapter: turns LSB-aligned core loads/stores into word-aligned lane-strobed bus
// accesses, with legality checking, a bus-wait timeout and a one-cycle completion pulse.
module minrv32_dbus #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic            clk_i,
  input logic            reset_i,
  minrv32_dbus_if.master dbus_io
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  localparam logic [15:0] TimeoutLim = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  shift_q, shift_d;
  logic [3:0]  rmask_q, rmask_d;
  logic        bus_valid_q, bus_valid_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic        core_ready_q, core_ready_d;
  logic [31:0] core_rdata_q, core_rdata_d;
  logic        core_err_q, core_err_d;

  logic [3:0]  req_mask;
  logic        req_illegal;
  logic        req_noop;
  logic [15:0] cnt_inc;
  logic [31:0] load_shifted;
  logic [31:0] load_keep;

  function automatic logic mask_ok(logic [3:0] m);
    return m inside {4'h0, 4'h1, 4'h3, 4'hF};
  endfunction

  assign req_mask    = dbus_io.core_rmask | dbus_io.core_wmask;
  assign req_noop    = (req_mask == 4'h0);
  assign req_illegal = ((|dbus_io.core_rmask) && (|dbus_io.core_wmask)) ||
                       !mask_ok(dbus_io.core_rmask) || !mask_ok(dbus_io.core_wmask) ||
                       ((req_mask == 4'h3) && dbus_io.core_addr[0]) ||
                       ((req_mask == 4'hF) && (dbus_io.core_addr[1:0] != 2'b00));

  assign cnt_inc      = cnt_q + 16'd1;
  assign load_shifted = dbus_io.bus_rdata >> {shift_q, 3'b000};
  assign load_keep    = {{8{rmask_q[3]}}, {8{rmask_q[2]}}, {8{rmask_q[1]}}, {8{rmask_q[0]}}};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    rmask_d      = rmask_q;
    bus_valid_d  = 1'b0;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_wstrb_d  = bus_wstrb_q;
    core_ready_d = 1'b0;
    core_rdata_d = 32'h0;
    core_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (dbus_io.core_valid) begin
          if (req_illegal || req_noop) begin
            state_d      = StResp;
            core_ready_d = 1'b1;
            core_err_d   = req_illegal;
          end else begin
            state_d     = StBus;
            cnt_d       = 16'h0;
            shift_d     = dbus_io.core_addr[1:0];
            rmask_d     = dbus_io.core_rmask;
            bus_valid_d = 1'b1;
            bus_addr_d  = {dbus_io.core_addr[31:2], 2'b00};
            bus_wdata_d = dbus_io.core_wdata << {dbus_io.core_addr[1:0], 3'b000};
            bus_wstrb_d = dbus_io.core_wmask << dbus_io.core_addr[1:0];
          end
        end
      end
      StBus: begin
        // A response in the same cycle the wait limit is hit takes priority over the timeout.
        if (dbus_io.bus_ready) begin
          state_d      = StResp;
          core_ready_d = 1'b1;
          core_err_d   = dbus_io.bus_err;
          core_rdata_d = (bus_wstrb_q == 4'h0) ? (load_shifted & load_keep) : 32'h0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TimeoutLim) begin
            state_d      = StResp;
            core_ready_d = 1'b1;
            core_err_d   = 1'b1;
          end else begin
            bus_valid_d = 1'b1;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      cnt_q        <= 16'h0;
      shift_q      <= 2'b00;
      rmask_q      <= 4'h0;
      bus_valid_q  <= 1'b0;
      bus_addr_q   <= 32'h0;
      bus_wdata_q  <= 32'h0;
      bus_wstrb_q  <= 4'h0;
      core_ready_q <= 1'b0;
      core_rdata_q <= 32'h0;
      core_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      rmask_q      <= rmask_d;
      bus_valid_q  <= bus_valid_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_wstrb_q  <= bus_wstrb_d;
      core_ready_q <= core_ready_d;
      core_rdata_q <= core_rdata_d;
      core_err_q   <= core_err_d;
    end
  end

  assign dbus_io.bus_valid  = bus_valid_q;
  assign dbus_io.bus_addr   = bus_addr_q;
  assign dbus_io.bus_wdata  = bus_wdata_q;
  assign dbus_io.bus_wstrb  = bus_wstrb_q;
  assign dbus_io.core_ready = core_ready_q;
  assign dbus_io.core_rdata = core_rdata_q;
  assign dbus_io.core_err   = core_err_q;

endmodule
